ps2_scancode_ctrl: RTL and testbench
====================================

Name: ps2_scancode_ctrl

Overview:
Sequencing controller that sits between the PS/2 byte receiver and the application logic. It consumes raw received bytes and decodes the E0 (extended) and F0 (break) prefix sequences. Complete key events (code, extended, break) are queued in a small FIFO and delivered over a valid/ready handshake. Stalled multi-byte sequences are aborted by a timeout, and non-key bytes (ACK, BAT, echo, errors) are filtered out.

Parameters:
FIFO_DEPTH, 4, number of queued key events; power of two, minimum 2.
TIMEOUT_CYCLES, 50000, clock cycles allowed between bytes of one sequence before abort (1 ms at 50 MHz).

Ports:
clock  input  1  system clock; all state on the rising edge.
reset  input  1  asynchronous, active-low reset.
rx_data  input  8  received scancode byte.
rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
ev_code  output  8  key code at the FIFO head.
ev_ext  output  1  head event carried an E0 prefix.
ev_brk  output  1  head event is a key release (F0 prefix).
ev_valid  output  1  FIFO not empty.
ev_ready  input  1  consumer accepts the head event.
ev_count  output  $clog2(FIFO_DEPTH)+1  number of queued events.
overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
seq_error  output  1  one-cycle pulse on a malformed sequence or timeout.
clear  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous): decoder goes to IDLE; FIFO is emptied; timeout counter = 0; ev_valid=0, ev_count=0, ev_code=0, ev_ext=0, ev_brk=0, overflow=0, seq_error=0.
- Reset mid-sequence discards any partial prefix state; nothing is pushed.
- Decoder states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP (pause sequence).
- On rx_valid in IDLE:
  - 0xE0 -> GOT_E0.
  - 0xF0 -> GOT_F0.
  - 0xE1 -> SKIP with skip counter = 7.
  - 0xFA, 0xAA, 0xEE, 0xFE, 0x00, 0xFF are discarded; state stays IDLE.
  - Any other byte -> push {code, ext=0, brk=0}; state stays IDLE.
- GOT_E0:
  - 0xF0 -> GOT_E0F0.
  - 0xE0 -> stay in GOT_E0, no error.
  - Other byte -> push {code, ext=1, brk=0} -> IDLE.
- GOT_F0:
  - Key byte -> push {code, ext=0, brk=1} -> IDLE.
  - 0xE0 -> seq_error, then GOT_E0.
  - 0xF0 -> seq_error, stay in GOT_F0.
- GOT_E0F0:
  - Key byte -> push {code, ext=1, brk=1} -> IDLE.
  - 0xE0 or 0xF0 -> seq_error, then GOT_E0 or GOT_E0F0 respectively.
- SKIP: each rx_valid decrements the skip counter; at 0, return to IDLE (see optional feature).
- Filter bytes (0xFA, 0xAA, 0xEE, 0xFE, 0x00, 0xFF) received in GOT_* or SKIP states -> seq_error, then IDLE.
- Timeout:
  - The counter runs only outside IDLE and resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, the decoder pulses seq_error and returns to IDLE.
  - If rx_valid arrives in the expiry cycle, the byte wins and the timeout does not fire.
- Latency: a push is registered on the clock edge that samples rx_valid. When the FIFO was empty, ev_valid rises in the next cycle.
- FIFO is first-word fall-through: ev_code, ev_ext and ev_brk show the head entry whenever ev_valid=1, and are held stable until it is popped.
- Pop occurs on ev_valid && ev_ready. ev_ready with an empty FIFO is ignored.
- Full FIFO:
  - A push without a simultaneous pop drops the new event and sets overflow.
  - A push with a simultaneous pop succeeds and ev_count is unchanged.
- Push and pop in the same cycle at any occupancy: both occur, and ev_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- overflow is cleared only by clear=1 or reset. If clear and a new overflow occur in the same cycle, the flag ends up set.

Optional Feature:
PS2_PAUSE_DECODE_EN.
- Defined: the SKIP state compares the 7 bytes after 0xE1 against 14 77 E1 F0 14 F0 77.
  - Full match -> push {code=0x77, ext=1, brk=0} as the Pause event.
  - Mismatch -> seq_error and IDLE.
- Undefined: the 0xE1 byte and the following 7 bytes are silently discarded, and no event is pushed.

Decomposition:
- Package ps2_pkg holds:
  - the decoder state enum;
  - byte constants PS2_EXT=0xE0, PS2_BRK=0xF0, PS2_PAUSE=0xE1, PS2_ACK=0xFA, PS2_BAT=0xAA, PS2_ECHO=0xEE, PS2_RESEND=0xFE, PS2_ERR0=0x00, PS2_ERR1=0xFF;
  - the 10-bit packed event type {ext, brk, code[7:0]}.
- One sub-module: ps2_event_fifo, a parameterised first-word fall-through FIFO with push, pop, count and full/empty outputs. The decoder, timeout counter and overflow flag stay in the top module.

Test Plan:
- Byte 0x1C -> one cycle later ev_valid=1, ev_code=0x1C, ev_ext=0, ev_brk=0; after ev_ready=1 for one cycle, ev_valid=0 and ev_count=0.
- Bytes E0 F0 75 -> a single event with ev_code=0x75, ev_ext=1, ev_brk=1; bytes FA and AA sent in IDLE produce no event.
- With ev_ready=0, send five make codes 0x15 0x1D 0x24 0x2D 0x2C -> ev_count=4, overflow=1, head=0x15; popping all four yields 15 1D 24 2D; clear=1 -> overflow=0.
- With a full FIFO, issue a push and a pop in the same cycle -> overflow stays 0, ev_count stays 4, and the new code sits at the tail.
- Byte E0, then idle for TIMEOUT_CYCLES -> one seq_error pulse; a following 0x1C yields ev_ext=0. Separately, assert reset=0 after F0 -> no event, and the following 0x1C yields ev_brk=0.
- Bytes E1 14 77 E1 F0 14 F0 77 -> with PS2_PAUSE_DECODE_EN, one event {0x77, ext=1, brk=0}; without it, no event; in both cases a following 0x1C decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: decoder states, PS/2 byte constants, packed key event type and byte helpers.
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP} dec_state_e;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [55:0] PS2_PAUSE_SEQ = 56'h14_77_E1_F0_14_F0_77;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;
  function automatic logic is_filter(input logic [7:0] b);
    return b == PS2_ACK || b == PS2_BAT || b == PS2_ECHO || b == PS2_RESEND ||
           b == PS2_ERR0 || b == PS2_ERR1;
  endfunction
  // Expected pause byte while c bytes remain (c=7 is the first byte after E1).
  function automatic logic [7:0] pause_byte(input logic [2:0] c);
    return 8'(PS2_PAUSE_SEQ >> {c - 3'd1, 3'b000});
  endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word fall-through FIFO; a pop frees room for a same-cycle push when full.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: decodes E0/F0/E1 scancode sequences into queued key events.
// Define PS2_PAUSE_DECODE_EN to turn the E1 pause sequence into an E0-77 make event.
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  output logic                          seq_error,
  input  logic                          clear
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  dec_state_e state, state_nx;
  logic [2:0] skip_cnt;
  logic [TW-1:0] tmo_cnt;
  logic filt, expire, err_nx, push, pop, full, empty;
  ps2_event_t push_ev, head_ev;
  assign filt = is_filter(rx_data);
  assign expire = state != IDLE && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign pop = ev_valid && ev_ready;
  assign ev_valid = !empty;
  assign {ev_ext, ev_brk, ev_code} = head_ev;
  always_comb begin
    state_nx = state;
    push = 1'b0;
    push_ev = {1'b0, 1'b0, rx_data};
    err_nx = expire;
    if (expire) state_nx = IDLE;
    else if (rx_valid) begin
      if (state != IDLE && filt) begin
        err_nx = 1'b1;
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: begin
            state_nx = rx_data == PS2_EXT ? GOT_E0 : rx_data == PS2_BRK ? GOT_F0 :
                       rx_data == PS2_PAUSE ? SKIP : IDLE;
            push = state_nx == IDLE && !filt;
          end
          GOT_E0: begin
            state_nx = rx_data == PS2_BRK ? GOT_E0F0 : rx_data == PS2_EXT ? GOT_E0 : IDLE;
            push = state_nx == IDLE;
            push_ev.ext = 1'b1;
          end
          GOT_F0, GOT_E0F0: begin
            err_nx = rx_data == PS2_EXT || rx_data == PS2_BRK;
            state_nx = rx_data == PS2_EXT ? GOT_E0 : rx_data == PS2_BRK ? state : IDLE;
            push = !err_nx;
            push_ev.ext = state == GOT_E0F0;
            push_ev.brk = 1'b1;
          end
          SKIP: begin
`ifdef PS2_PAUSE_DECODE_EN
            err_nx = rx_data != pause_byte(skip_cnt);
            state_nx = err_nx || skip_cnt == 3'd1 ? IDLE : SKIP;
            push = !err_nx && skip_cnt == 3'd1;
            push_ev = {1'b1, 1'b0, 8'h77};
`else
            state_nx = skip_cnt == 3'd1 ? IDLE : SKIP;
`endif
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      skip_cnt <= '0;
      tmo_cnt <= '0;
      seq_error <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      seq_error <= err_nx;
      tmo_cnt <= state == IDLE || rx_valid || expire ? '0 : tmo_cnt + 1'b1;
      if (rx_valid && state == IDLE && rx_data == PS2_PAUSE) skip_cnt <= 3'd7;
      else if (rx_valid && state == SKIP) skip_cnt <= skip_cnt - 1'b1;
      overflow <= (overflow && !clear) || (push && full && !pop);
    end
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .W(10)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(push_ev),
    .dout(head_ev),
    .count(ev_count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb_ps2_scancode_ctrl: directed checks of decoding, FIFO behaviour, overflow, timeout and reset.
module tb_ps2_scancode_ctrl;
  localparam int TMO = 20;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic ev_ready = 1'b0;
  logic clear = 1'b0;
  logic [7:0] ev_code;
  logic ev_ext, ev_brk, ev_valid, overflow, seq_error;
  logic [2:0] ev_count;
  int errors = 0;
  int checks = 0;
  int pulses, first_at;

  ps2_scancode_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_count(ev_count), .overflow(overflow),
    .seq_error(seq_error), .clear(clear)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, "_code"}, 32'(ev_code), 32'(code));
    chk({tag, "_ext"}, 32'(ev_ext), 32'(ext));
    chk({tag, "_brk"}, 32'(ev_brk), 32'(brk));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_count", 32'(ev_count), 0);
    chk("rst_code", 32'(ev_code), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_err", 32'(seq_error), 0);
    reset = 1'b1;
    tick();
    send(8'h1C);
    chk_head("make", 8'h1C, 1'b0, 1'b0);
    chk("make_count", 32'(ev_count), 1);
    pop_one();
    chk("pop_valid", 32'(ev_valid), 0);
    chk("pop_count", 32'(ev_count), 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk_head("extbrk", 8'h75, 1'b1, 1'b1);
    send(8'hFA);
    send(8'hAA);
    chk("filter_count", 32'(ev_count), 1);
    chk("filter_err", 32'(seq_error), 0);
    pop_one();
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    chk("fill_ovf0", 32'(overflow), 0);
    send(8'h2C);
    chk("full_count", 32'(ev_count), 4);
    chk("full_ovf", 32'(overflow), 1);
    chk_head("h0", 8'h15, 1'b0, 1'b0);
    pop_one();
    chk_head("h1", 8'h1D, 1'b0, 1'b0);
    pop_one();
    chk_head("h2", 8'h24, 1'b0, 1'b0);
    pop_one();
    chk_head("h3", 8'h2D, 1'b0, 1'b0);
    pop_one();
    chk("drain_count", 32'(ev_count), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    rx_data = 8'h3C;
    rx_valid = 1'b1;
    ev_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    ev_ready = 1'b0;
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_count", 32'(ev_count), 4);
    chk_head("pp_h", 8'h1D, 1'b0, 1'b0);
    pop_one();
    pop_one();
    pop_one();
    chk_head("pp_tail", 8'h3C, 1'b0, 1'b0);
    pop_one();
    send(8'hE0);
    pulses = 0;
    first_at = -1;
    for (int i = 1; i <= TMO + 10; i++) begin
      tick();
      if (seq_error) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    chk("tmo_pulses", 32'(pulses), 1);
    chk("tmo_when", 32'(first_at), TMO);
    send(8'h1C);
    chk_head("after_tmo", 8'h1C, 1'b0, 1'b0);
    pop_one();
    send(8'hE0);
    repeat (TMO - 1) tick();
    send(8'h75);
    chk("win_err", 32'(seq_error), 0);
    chk_head("win", 8'h75, 1'b1, 1'b0);
    pop_one();
    send(8'hF0);
    send(8'hF0);
    chk("ff_err", 32'(seq_error), 1);
    send(8'h2C);
    chk_head("ff_key", 8'h2C, 1'b0, 1'b1);
    pop_one();
    send(8'hE0);
    send(8'hFA);
    chk("e0fa_err", 32'(seq_error), 1);
    chk("e0fa_count", 32'(ev_count), 0);
    send(8'hF0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rstmid_count", 32'(ev_count), 0);
    send(8'h1C);
    chk_head("rstmid_key", 8'h1C, 1'b0, 1'b0);
    pop_one();
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    chk("pause_err", 32'(seq_error), 0);
`ifdef PS2_PAUSE_DECODE_EN
    chk("pause_count", 32'(ev_count), 1);
    chk_head("pause", 8'h77, 1'b1, 1'b0);
    pop_one();
`else
    chk("pause_count", 32'(ev_count), 0);
`endif
    send(8'h1C);
    chk_head("post_pause", 8'h1C, 1'b0, 1'b0);
    chk("post_pause_count", 32'(ev_count), 1);
    pop_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
